uart_link_ctrl: RTL and testbench

- Sequences the UART command/response wrapper for the rest of the design.
- Command side: drains each completed 16-bit command (`cmd_rdy`/`cmd`) into a small FIFO, pulses `clr_cmd_rdy`, and presents commands to the consumer with a valid/ack handshake.
- Response side: shares the single TX byte path (`resp`/`trmt`/`tx_done`) among NUM_REQ requesters using round-robin arbitration, one byte in flight at a time.

---
 rtl/uart_link_pkg.sv | 17 +
 rtl/uart_cmd_fifo.sv | 58 +++++
 rtl/uart_link_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_uart_link_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// Shared types and constants for the UART command/response link controller.
package uart_link_pkg;

   localparam int unsigned CMD_DEPTH_DEF = 4;
   localparam int unsigned NUM_REQ_DEF   = 2;
   localparam int unsigned CMD_W         = 16;
   localparam int unsigned BYTE_W        = 8;

   localparam logic [BYTE_W-1:0] RESP_RST = 8'h00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      WAIT = 2'd2
   } tx_state_t;

endpackage

// File: rtl/uart_cmd_fifo.sv
// Synchronous command FIFO: push/pop, full/empty flags and head-of-queue output.
module uart_cmd_fifo
   import uart_link_pkg::*;
#(
   parameter int unsigned DEPTH = CMD_DEPTH_DEF,
   parameter int unsigned WIDTH = CMD_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   // Full is judged before any same-cycle pop, so a blocked push retries next cycle.
   always_comb begin
      full     = (cnt_q == CNT_W'(DEPTH));
      empty    = (cnt_q == '0);
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
      rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
      cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
      head     = empty ? '0 : mem_q[rd_ptr_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/uart_link_ctrl.sv
// UART link sequencer: command FIFO drain plus round-robin shared TX byte path.
// Optional TX completion timeout enabled by defining UART_TX_TIMEOUT_EN.
module uart_link_ctrl
   import uart_link_pkg::*;
#(
   parameter int unsigned CMD_DEPTH  = CMD_DEPTH_DEF,
   parameter int unsigned NUM_REQ    = NUM_REQ_DEF
`ifdef UART_TX_TIMEOUT_EN
   ,
   parameter int unsigned TX_TIMEOUT = 65535
`endif
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_rdy,
   input  logic [CMD_W-1:0]          cmd,
   output logic                      clr_cmd_rdy,
   output logic                      cmd_vld,
   output logic [CMD_W-1:0]          cmd_out,
   input  logic                      cmd_ack,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [BYTE_W*NUM_REQ-1:0] req_byte,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [BYTE_W-1:0]         resp,
   output logic                      trmt,
   input  logic                      tx_done,
   output logic                      tx_busy,
   output logic                      tx_err
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic cmd_full;
   logic cmd_empty;
   logic cmd_push;
   logic cmd_pop;

   // Wrapper command is only consumed when it lands in the FIFO, never under reset.
   always_comb begin
      cmd_push    = cmd_rdy & ~cmd_full & ~rst;
      cmd_pop     = cmd_vld & cmd_ack;
      clr_cmd_rdy = cmd_push;
      cmd_vld     = ~cmd_empty;
   end

   uart_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .WIDTH (CMD_W)
   ) u_cmd_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cmd_push),
      .push_data (cmd),
      .pop       (cmd_pop),
      .full      (cmd_full),
      .empty     (cmd_empty),
      .head      (cmd_out)
   );

   logic [BYTE_W-1:0] req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_byte[g*BYTE_W +: BYTE_W];
   end

   tx_state_t          state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [BYTE_W-1:0]  resp_q, resp_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               trmt_q, trmt_d;
   logic               busy_q, busy_d;
   logic               tx_done_q;
   logic               done_evt;
   logic               arb_found;
   logic [PTR_W-1:0]   arb_win;
   logic [PTR_W-1:0]   arb_cand;
   logic               tmo_hit;

   // Round-robin search starting one past the last winner.
   always_comb begin
      arb_found = 1'b0;
      arb_win   = ptr_q;
      arb_cand  = ptr_q;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         arb_cand = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
         if (!arb_found && req[arb_cand]) begin
            arb_found = 1'b1;
            arb_win   = arb_cand;
         end
      end
   end

   assign done_evt = tx_done & ~tx_done_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      resp_d  = resp_q;
      gnt_d   = '0;
      trmt_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d        = SEND;
               ptr_d          = arb_win;
               resp_d         = req_bytes[arb_win];
               gnt_d[arb_win] = 1'b1;
               trmt_d         = 1'b1;
            end
         end
         SEND: state_d = WAIT;
         WAIT: begin
            if (done_evt || tmo_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= PTR_W'(NUM_REQ - 1);
         resp_q    <= RESP_RST;
         gnt_q     <= '0;
         trmt_q    <= 1'b0;
         busy_q    <= 1'b0;
         tx_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         resp_q    <= resp_d;
         gnt_q     <= gnt_d;
         trmt_q    <= trmt_d;
         busy_q    <= busy_d;
         tx_done_q <= tx_done;
      end
   end

`ifdef UART_TX_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TX_TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
   logic             tx_err_q, tx_err_d;

   // Counter restarts on entry to WAIT; a completion in the last cycle still wins.
   always_comb begin
      tmo_cnt_d = tmo_cnt_q;
      tx_err_d  = tx_err_q;
      tmo_hit   = 1'b0;
      if (state_q == SEND) begin
         tmo_cnt_d = '0;
      end else if (state_q == WAIT && !done_evt) begin
         if (tmo_cnt_q == TMO_W'(TX_TIMEOUT - 1)) begin
            tmo_hit  = 1'b1;
            tx_err_d = 1'b1;
         end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q <= '0;
         tx_err_q  <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         tx_err_q  <= tx_err_d;
      end
   end

   assign tx_err = tx_err_q;
`else
   assign tmo_hit = 1'b0;
   assign tx_err  = 1'b0;
`endif

   assign gnt     = gnt_q;
   assign resp    = resp_q;
   assign trmt    = trmt_q;
   assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Directed bench for uart_link_ctrl: table-driven command path, hand sequences for TX.
module tb_uart_link_ctrl;

   logic        clk;
   logic        rst;
   logic        cmd_rdy;
   logic [15:0] cmd;
   logic        clr_cmd_rdy;
   logic        cmd_vld;
   logic [15:0] cmd_out;
   logic        cmd_ack;
   logic [1:0]  req;
   logic [15:0] req_byte;
   logic [1:0]  gnt;
   logic [7:0]  resp;
   logic        trmt;
   logic        tx_done;
   logic        tx_busy;
   logic        tx_err;

   int n_checks;
   int n_pass;

   uart_link_ctrl #(
      .CMD_DEPTH  (4),
      .NUM_REQ    (2)
`ifdef UART_TX_TIMEOUT_EN
      ,
      .TX_TIMEOUT (16)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_rdy     (cmd_rdy),
      .cmd         (cmd),
      .clr_cmd_rdy (clr_cmd_rdy),
      .cmd_vld     (cmd_vld),
      .cmd_out     (cmd_out),
      .cmd_ack     (cmd_ack),
      .req         (req),
      .req_byte    (req_byte),
      .gnt         (gnt),
      .resp        (resp),
      .trmt        (trmt),
      .tx_done     (tx_done),
      .tx_busy     (tx_busy),
      .tx_err      (tx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rdy;
      logic [15:0] cmd;
      logic        ack;
      logic        clr;
      logic        vld;
      logic [15:0] out;
   } cmd_vec_t;

   localparam int NV = 21;
   cmd_vec_t vec [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Returns the sample index (1-based) at which trmt was seen, or -1.
   task automatic wait_trmt(input int max_cyc, output int cyc);
      cyc = -1;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk);
         #1;
         if (trmt) begin
            cyc = c;
            break;
         end
      end
   endtask

   int cyc;
   int extra;
   int busy_drop;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      cmd_rdy  = 1'b0;
      cmd      = 16'h0000;
      cmd_ack  = 1'b0;
      req      = 2'b00;
      req_byte = 16'h0000;
      tx_done  = 1'b0;

      //             rdy   cmd       ack   clr   vld   out
      vec[0]  = '{1'b1, 16'hA53C, 1'b0, 1'b1, 1'b0, 16'h0000};
      vec[1]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA53C};
      vec[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'hA53C};
      vec[3]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};
      vec[4]  = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000};
      vec[5]  = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001};
      vec[6]  = '{1'b1, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001};
      vec[7]  = '{1'b1, 16'h0004, 1'b0, 1'b1, 1'b1, 16'h0001};
      vec[8]  = '{1'b1, 16'h0005, 1'b0, 1'b0, 1'b1, 16'h0001};
      vec[9]  = '{1'b1, 16'h0005, 1'b1, 1'b0, 1'b1, 16'h0001};
      vec[10] = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 16'h0002};
      vec[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002};
      vec[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0003};
      vec[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0004};
      vec[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0005};
      vec[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000};
      vec[16] = '{1'b1, 16'h0077, 1'b1, 1'b1, 1'b0, 16'h0000};
      vec[17] = '{1'b1, 16'h0088, 1'b1, 1'b1, 1'b1, 16'h0077};
      vec[18] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0088};
      vec[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0088};
      vec[20] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000};

      // Reset state
      @(negedge clk);
      #1;
      chk("rst.clr_cmd_rdy", 32'(clr_cmd_rdy), 32'd0);
      chk("rst.cmd_vld",     32'(cmd_vld),     32'd0);
      chk("rst.cmd_out",     32'(cmd_out),     32'h0000);
      chk("rst.gnt",         32'(gnt),         32'd0);
      chk("rst.resp",        32'(resp),        32'h00);
      chk("rst.trmt",        32'(trmt),        32'd0);
      chk("rst.tx_busy",     32'(tx_busy),     32'd0);
      chk("rst.tx_err",      32'(tx_err),      32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Command path vectors
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         cmd_rdy = vec[i].rdy;
         cmd     = vec[i].cmd;
         cmd_ack = vec[i].ack;
         #1;
         chk($sformatf("cmd[%0d].clr_cmd_rdy", i), 32'(clr_cmd_rdy), 32'(vec[i].clr));
         chk($sformatf("cmd[%0d].cmd_vld", i), 32'(cmd_vld), 32'(vec[i].vld));
         if (vec[i].vld) begin
            chk($sformatf("cmd[%0d].cmd_out", i), 32'(cmd_out), 32'(vec[i].out));
         end
      end
      cmd_rdy = 1'b0;
      cmd_ack = 1'b0;

      // Round-robin alternation with continuously held requests
      req_byte = {8'h22, 8'h11};
      req      = 2'b11;
      for (int b = 0; b < 3; b++) begin
         wait_trmt(4, cyc);
         chk($sformatf("arb[%0d].trmt_latency", b), 32'(cyc), 32'd1);
         chk($sformatf("arb[%0d].gnt", b), 32'(gnt), (b % 2 == 1) ? 32'd2 : 32'd1);
         chk($sformatf("arb[%0d].resp", b), 32'(resp), (b % 2 == 1) ? 32'h22 : 32'h11);
         chk($sformatf("arb[%0d].busy", b), 32'(tx_busy), 32'd1);
         if (b == 2) req = 2'b00;
         @(negedge clk);
         #1;
         chk($sformatf("arb[%0d].trmt_one_cycle", b), 32'(trmt), 32'd0);
         chk($sformatf("arb[%0d].gnt_one_cycle", b), 32'(gnt), 32'd0);
         extra = 0;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            if (trmt) extra++;
         end
         chk($sformatf("arb[%0d].no_trmt_before_done", b), 32'(extra), 32'd0);
         chk($sformatf("arb[%0d].busy_waiting", b), 32'(tx_busy), 32'd1);
         @(negedge clk);
         tx_done = 1'b1;
         @(negedge clk);
         tx_done = 1'b0;
         #1;
         chk($sformatf("arb[%0d].idle_after_done", b), 32'(tx_busy), 32'd0);
         chk($sformatf("arb[%0d].resp_held", b), 32'(resp), (b % 2 == 1) ? 32'h22 : 32'h11);
      end

      // tx_done level held high across a new transfer is not a completion
      @(negedge clk);
      tx_done = 1'b1;
      req     = 2'b01;
      wait_trmt(4, cyc);
      chk("held.trmt_latency", 32'(cyc), 32'd1);
      chk("held.gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      busy_drop = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (!tx_busy) busy_drop++;
      end
      chk("held.stays_in_wait", 32'(busy_drop), 32'd0);
      @(negedge clk);
      tx_done = 1'b0;
      #1;
      chk("held.busy_after_fall", 32'(tx_busy), 32'd1);
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      #1;
      chk("held.idle_after_rise", 32'(tx_busy), 32'd0);
      tx_done = 1'b0;

      // Asynchronous reset in the middle of WAIT
      req = 2'b01;
      wait_trmt(4, cyc);
      chk("rstw.trmt_latency", 32'(cyc), 32'd1);
      chk("rstw.resp", 32'(resp), 32'h11);
      req = 2'b00;
      @(negedge clk);
      #2;
      rst     = 1'b1;
      cmd_rdy = 1'b1;
      #1;
      chk("rstw.trmt",        32'(trmt),        32'd0);
      chk("rstw.tx_busy",     32'(tx_busy),     32'd0);
      chk("rstw.gnt",         32'(gnt),         32'd0);
      chk("rstw.resp",        32'(resp),        32'h00);
      chk("rstw.clr_cmd_rdy", 32'(clr_cmd_rdy), 32'd0);
      @(negedge clk);
      rst     = 1'b0;
      cmd_rdy = 1'b0;
      #1;
      chk("rstw.cmd_vld", 32'(cmd_vld), 32'd0);
      req = 2'b10;
      wait_trmt(4, cyc);
      chk("rstw.post_trmt_latency", 32'(cyc), 32'd1);
      chk("rstw.post_gnt", 32'(gnt), 32'd2);
      chk("rstw.post_resp", 32'(resp), 32'h22);
      req = 2'b00;

`ifdef UART_TX_TIMEOUT_EN
      // 16 WAIT cycles without completion, then forced back to IDLE with sticky error
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         #1;
      end
      chk("tmo.busy_last_wait", 32'(tx_busy), 32'd1);
      chk("tmo.err_before", 32'(tx_err), 32'd0);
      @(negedge clk);
      #1;
      chk("tmo.idle", 32'(tx_busy), 32'd0);
      chk("tmo.err_set", 32'(tx_err), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #1;
      end
      chk("tmo.err_sticky", 32'(tx_err), 32'd1);
`else
      // Without the timeout WAIT is held indefinitely
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         #1;
      end
      chk("notmo.busy", 32'(tx_busy), 32'd1);
      chk("notmo.err", 32'(tx_err), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
